// File: rtl/ysyx_23060208_clint_pkg.sv
// Shared constants and state types for the core-local timer (CLINT) on the EXU data-side bus.
package ysyx_23060208_clint_pkg;

    localparam logic [31:0] CLINT_BASE_ADDR = 32'ha000_0048;

    localparam logic [3:0] OFF_MTIME_LO    = 4'h0;
    localparam logic [3:0] OFF_MTIME_HI    = 4'h4;
    localparam logic [3:0] OFF_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] OFF_MTIMECMP_HI = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] WSTRB_BYTE = 3'b001;
    localparam logic [2:0] WSTRB_HALF = 3'b011;
    localparam logic [2:0] WSTRB_WORD = 3'b111;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/ysyx_23060208_clint_timer.sv
// Prescaled 64-bit mtime counter, writable mtimecmp and the registered timer interrupt.
module ysyx_23060208_clint_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmp_we_lo,
    input  logic        cmp_we_hi,
    input  logic [31:0] cmp_wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          tick;

    assign tick = (prescaler == PW'(TICK_DIV - 1));

    // The irq compares the values held before this edge, so a new mtimecmp shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (cmp_we_lo) begin
                mtimecmp[31:0] <= cmp_wdata;
            end
            if (cmp_we_hi) begin
                mtimecmp[63:32] <= cmp_wdata;
            end
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/ysyx_23060208_clint.sv
// CLINT responder on the EXU data-side handshake bus: address decode, independent read and write FSMs.
module ysyx_23060208_clint
    import ysyx_23060208_clint_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = CLINT_BASE_ADDR,
    parameter int                    TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dsram_awaddr,
    input  logic                  dsram_awvalid,
    output logic                  dsram_awready,
    input  logic [DATA_WIDTH-1:0] dsram_wdata,
    input  logic [2:0]            dsram_wstrb,
    input  logic                  dsram_wvalid,
    output logic                  dsram_wready,
    output logic [1:0]            dsram_bresp,
    output logic                  dsram_bvalid,
    input  logic                  dsram_bready,
    input  logic [DATA_WIDTH-1:0] dsram_araddr,
    input  logic                  dsram_arvalid,
    output logic                  dsram_arready,
    output logic [DATA_WIDTH-1:0] dsram_rdata,
    output logic [1:0]            dsram_rresp,
    output logic                  dsram_rvalid,
    input  logic                  dsram_rready,
    output logic                  timer_irq
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        cmp_we_lo;
    logic        cmp_we_hi;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] ar_off;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [31:0]           mtime_hi_shadow;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_done;
    logic                  w_done;
    logic                  commit;
    logic [DATA_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [2:0]            w_strb_q;
    logic [DATA_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [2:0]            wr_strb;
    logic [DATA_WIDTH-1:0] wr_off;
    logic                  wr_err;
    logic [1:0]            bresp_q;

    ysyx_23060208_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cmp_we_lo (cmp_we_lo),
        .cmp_we_hi (cmp_we_hi),
        .cmp_wdata (wr_data),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .timer_irq (timer_irq)
    );

    // Reads of the high mtime word come from the shadow taken at the last low-word read.
    always_comb begin
        ar_off = dsram_araddr - BASE_ADDR;
        rd_err = (ar_off[DATA_WIDTH-1:4] != '0) || (ar_off[1:0] != 2'b00);
        case (ar_off[3:0])
            OFF_MTIME_LO:    rd_val = mtime[31:0];
            OFF_MTIME_HI:    rd_val = mtime_hi_shadow;
            OFF_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            default:         rd_val = mtimecmp[63:32];
        endcase
    end

    always_comb begin
        r_next        = r_state;
        dsram_arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                dsram_arready = 1'b1;
                if (dsram_arvalid) r_next = R_RESP;
            end
            R_RESP: begin
                if (dsram_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs        = dsram_arvalid && dsram_arready;
    assign dsram_rvalid = (r_state == R_RESP);
    assign dsram_rdata  = rdata_q;
    assign dsram_rresp  = rresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= R_IDLE;
            rdata_q         <= '0;
            rresp_q         <= RESP_OKAY;
            mtime_hi_shadow <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_err ? '0 : rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                if (!rd_err && ar_off[3:0] == OFF_MTIME_LO) begin
                    mtime_hi_shadow <= mtime[63:32];
                end
            end
        end
    end

    // A beat captured in an earlier cycle is replayed from its holding register at commit.
    always_comb begin
        wr_addr = aw_done ? aw_addr_q : dsram_awaddr;
        wr_data = w_done ? w_data_q : dsram_wdata;
        wr_strb = w_done ? w_strb_q : dsram_wstrb;
        wr_off  = wr_addr - BASE_ADDR;
        wr_err  = (wr_off[DATA_WIDTH-1:4] != '0) || (wr_off[1:0] != 2'b00)
                  || (wr_strb != WSTRB_WORD) || !wr_off[3];
    end

    always_comb begin
        w_next        = w_state;
        dsram_awready = (w_state != W_RESP) && !aw_done;
        dsram_wready  = (w_state != W_RESP) && !w_done;
        aw_hs         = dsram_awvalid && dsram_awready;
        w_hs          = dsram_wvalid && dsram_wready;
        commit        = (w_state != W_RESP) && (aw_done || aw_hs) && (w_done || w_hs);
        case (w_state)
            W_IDLE, W_WAIT: begin
                if (commit) w_next = W_RESP;
                else if (aw_hs || w_hs) w_next = W_WAIT;
            end
            W_RESP: begin
                if (dsram_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        cmp_we_lo = commit && !wr_err && (wr_off[3:0] == OFF_MTIMECMP_LO);
        cmp_we_hi = commit && !wr_err && (wr_off[3:0] == OFF_MTIMECMP_HI);
    end

    assign dsram_bvalid = (w_state == W_RESP);
    assign dsram_bresp  = bresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (commit) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_done   <= 1'b1;
                    aw_addr_q <= dsram_awaddr;
                end
                if (w_hs) begin
                    w_done   <= 1'b1;
                    w_data_q <= dsram_wdata;
                    w_strb_q <= dsram_wstrb;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Directed self-checking bench for the CLINT: timing, register map, errors, stalls and reset.
module tb_ysyx_23060208_clint;

    localparam logic [31:0] BASE = 32'ha000_0048;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [2:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        timer_irq;

    int          checks;
    int          errors;
    logic [63:0] model_mtime;

    ysyx_23060208_clint #(
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .TICK_DIV   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dsram_awaddr  (awaddr),
        .dsram_awvalid (awvalid),
        .dsram_awready (awready),
        .dsram_wdata   (wdata),
        .dsram_wstrb   (wstrb),
        .dsram_wvalid  (wvalid),
        .dsram_wready  (wready),
        .dsram_bresp   (bresp),
        .dsram_bvalid  (bvalid),
        .dsram_bready  (bready),
        .dsram_araddr  (araddr),
        .dsram_arvalid (arvalid),
        .dsram_arready (arready),
        .dsram_rdata   (rdata),
        .dsram_rresp   (rresp),
        .dsram_rvalid  (rvalid),
        .dsram_rready  (rready),
        .timer_irq     (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference mtime for TICK_DIV=1: one increment per edge out of reset.
    always @(posedge clk) begin
        if (rst) model_mtime <= 64'd0;
        else model_mtime <= model_mtime + 64'd1;
    end

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                           output int lat);
        int n;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = rdata;
        r = rresp;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                            input int gap, output logic [1:0] r, output int lat);
        awaddr  = a;
        awvalid = 1'b1;
        bready  = 1'b1;
        if (gap == 0) begin
            wdata  = d;
            wstrb  = s;
            wvalid = 1'b1;
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            awvalid = 1'b0;
        end
        if (gap > 0) begin
            wdata  = d;
            wstrb  = s;
            wvalid = 1'b1;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 1;
        while (!bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = bresp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, timer_irq} !== 6'b111000) begin
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {awready, wready, arready, bvalid, rvalid, timer_irq}, 6'b111000);
            errors++;
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'd0) begin
            $display("[TB] FAIL reset_data: got %h expected %h", {bresp, rresp, rdata}, 36'd0);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_count();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        apply_reset();
        repeat (20) @(negedge clk);
        do_read(BASE + 32'h0, d, r, lat);
        checks++;
        if (d !== 32'd20) begin
            $display("[TB] FAIL idle_mtime: got %0d expected %0d", d, 20);
            errors++;
        end
        checks++;
        if (r !== 2'b00) begin
            $display("[TB] FAIL idle_rresp: got %b expected %b", r, 2'b00);
            errors++;
        end
        checks++;
        if (lat !== 1) begin
            $display("[TB] FAIL idle_rlat: got %0d expected %0d", lat, 1);
            errors++;
        end
        do_read(BASE + 32'hC, d, r, lat);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL reset_cmp_hi: got %h expected %h", d, 32'hFFFF_FFFF);
            errors++;
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          guard;
        apply_reset();
        do_write(BASE + 32'hC, 32'h0, 3'b111, 0, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1) begin
            $display("[TB] FAIL cmp_hi_write: got resp %b lat %0d expected resp 00 lat 1", r, lat);
            errors++;
        end
        do_write(BASE + 32'h8, 32'h40, 3'b111, 2, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1) begin
            $display("[TB] FAIL cmp_lo_write: got resp %b lat %0d expected resp 00 lat 1", r, lat);
            errors++;
        end
        do_read(BASE + 32'h8, d, r, lat);
        checks++;
        if (d !== 32'h40) begin
            $display("[TB] FAIL cmp_lo_read: got %h expected %h", d, 32'h40);
            errors++;
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            $display("[TB] FAIL irq_early: got %b expected %b", timer_irq, 1'b0);
            errors++;
        end
        guard = 0;
        while (model_mtime < 64'h44 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (model_mtime >= 64'h3E) begin
                checks++;
                if (timer_irq !== (model_mtime >= 64'h41)) begin
                    $display("[TB] FAIL irq_edge: at mtime %h got %b expected %b",
                             model_mtime, timer_irq, model_mtime >= 64'h41);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        logic [31:0] exp_lo;
        do_read(BASE + 32'h10, d, r, lat);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            $display("[TB] FAIL rd_outside: got resp %b data %h expected resp 10 data 0", r, d);
            errors++;
        end
        do_read(BASE + 32'h2, d, r, lat);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            $display("[TB] FAIL rd_misalign: got resp %b data %h expected resp 10 data 0", r, d);
            errors++;
        end
        do_write(BASE + 32'h0, 32'h0, 3'b111, 0, r, lat);
        checks++;
        if (r !== 2'b10) begin
            $display("[TB] FAIL wr_mtime: got %b expected %b", r, 2'b10);
            errors++;
        end
        exp_lo = model_mtime[31:0];
        do_read(BASE + 32'h0, d, r, lat);
        checks++;
        if (d !== exp_lo) begin
            $display("[TB] FAIL mtime_kept: got %h expected %h", d, exp_lo);
            errors++;
        end
        do_write(BASE + 32'h8, 32'h1234, 3'b001, 0, r, lat);
        checks++;
        if (r !== 2'b10) begin
            $display("[TB] FAIL wr_byte: got %b expected %b", r, 2'b10);
            errors++;
        end
        do_read(BASE + 32'h8, d, r, lat);
        checks++;
        if (d !== 32'h40) begin
            $display("[TB] FAIL cmp_kept: got %h expected %h", d, 32'h40);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        araddr  = BASE + 32'h8;
        arvalid = 1'b1;
        rready  = 1'b0;
        awaddr  = BASE + 32'h8;
        awvalid = 1'b1;
        wdata   = 32'h55;
        wstrb   = 3'b111;
        wvalid  = 1'b1;
        bready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h40) begin
            $display("[TB] FAIL concurrent_read: got valid %b data %h expected valid 1 data 40",
                     rvalid, rdata);
            errors++;
        end
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            $display("[TB] FAIL concurrent_write: got valid %b resp %b expected valid 1 resp 00",
                     bvalid, bresp);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h40 || rresp !== 2'b00 || arready !== 1'b0) begin
                $display("[TB] FAIL stall_hold: got valid %b data %h resp %b arready %b expected 1 40 00 0",
                         rvalid, rdata, rresp, arready);
                errors++;
            end
        end
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            $display("[TB] FAIL stall_release: got valid %b arready %b expected 0 1", rvalid, arready);
            errors++;
        end
        do_read(BASE + 32'h8, d, r, lat);
        checks++;
        if (d !== 32'h55) begin
            $display("[TB] FAIL cmp_new: got %h expected %h", d, 32'h55);
            errors++;
        end
    endtask

    task automatic test_shadow();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        force dut.u_timer.mtime = 64'h0000_0000_FFFF_FFFF;
        do_read(BASE + 32'h0, d, r, lat);
        release dut.u_timer.mtime;
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL shadow_lo: got %h expected %h", d, 32'hFFFF_FFFF);
            errors++;
        end
        repeat (2) @(negedge clk);
        do_read(BASE + 32'h4, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            $display("[TB] FAIL shadow_hi: got data %h resp %b expected 0 00", d, r);
            errors++;
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        awaddr  = BASE + 32'hC;
        awvalid = 1'b1;
        wdata   = 32'h1;
        wstrb   = 3'b111;
        wvalid  = 1'b1;
        bready  = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            $display("[TB] FAIL pre_reset_bvalid: got %b expected %b", bvalid, 1'b1);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || timer_irq !== 1'b0 || awready !== 1'b1) begin
            $display("[TB] FAIL mid_reset: got bvalid %b irq %b awready %b expected 0 0 1",
                     bvalid, timer_irq, awready);
            errors++;
        end
        bready = 1'b1;
        do_read(BASE + 32'h8, d, r, lat);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL mid_reset_cmp_lo: got %h expected %h", d, 32'hFFFF_FFFF);
            errors++;
        end
        do_read(BASE + 32'hC, d, r, lat);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL mid_reset_cmp_hi: got %h expected %h", d, 32'hFFFF_FFFF);
            errors++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        test_reset();
        test_idle_count();
        test_irq();
        test_errors();
        test_back_to_back();
        test_shadow();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
